activation_scheduler: RTL and testbench

- Shares one FP32 sigmoid datapath (exponent, sum, divide, max/min clamp chain; combinational, multi-cycle settling) among NUM_REQ requesters, typically the output lanes of the systolic array.
- Round-robin arbitration, valid/ready handshakes, and a fixed settle-count wait before sampling the datapath result.
- Also handles the trivial activations (ReLU, passthrough) locally, so those never occupy the shared unit.

---
 rtl/tpu_act_pkg.sv | 22 ++
 rtl/activation_scheduler_rr_arbiter.sv | 31 +++
 rtl/activation_scheduler.sv | 119 +++++++++++
 tb/tb_activation_scheduler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tpu_act_pkg.sv
// Shared types and constants for the activation scheduler.
//   act_mode_t    : activation select codes (code 3 is reserved and behaves as PASS)
//   FP_ZERO/FP_ONE: FP32 constants
//   sched_state_t : scheduler FSM states
package tpu_act_pkg;

  typedef enum logic [1:0] {
    ACT_PASS    = 2'd0,
    ACT_RELU    = 2'd1,
    ACT_SIGMOID = 2'd2
  } act_mode_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/activation_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req [NUM_REQ] : request vector
//   ptr [IW]      : highest-priority lane this cycle (must be < NUM_REQ)
//   gnt [NUM_REQ] : one-hot grant (all zero when no request)
//   idx [IW]      : granted lane index (0 when no request)
//   any           : at least one request present
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  // Scan offsets from farthest to nearest so the nearest lane at/after ptr wins.
  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    any = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) idx = IW'(j);
    end
    gnt = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/activation_scheduler.sv
// activation_scheduler: shares one external combinational FP32 sigmoid datapath
// among NUM_REQ lanes; PASS/RELU are resolved locally in one cycle.
//   clk, rst_n          : clock, async active-low reset
//   mode[2]             : activation select, sampled at grant (3 = PASS)
//   req_valid/req_data  : per-lane requests, lane i at req_data[32i+:32]
//   req_ready           : one-hot accept pulse (combinational, IDLE only)
//   sig_in / sig_out    : shared datapath operand / result
//   resp_valid/data/id  : registered response, held until resp_ready
//   op_count            : completed-op counter when ACT_SCHED_STATS_EN is defined,
//                         constant 0 otherwise
module activation_scheduler
  import tpu_act_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int SETTLE_CYCLES = 3,
  localparam int IW            = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           sig_in,
  input  logic [31:0]           sig_out,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic [IW-1:0]         resp_id,
  input  logic                  resp_ready,
  output logic [31:0]           op_count
);

  localparam logic [3:0]    CNT_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] LAST     = IW'(NUM_REQ - 1);

  sched_state_t               state;
  logic [IW-1:0]              ptr;
  logic [3:0]                 settle_cnt;
  logic [NUM_REQ-1:0]         gnt;
  logic [IW-1:0]              gidx;
  logic                       any;
  logic [NUM_REQ-1:0][31:0]   lanes;
  logic [31:0]                operand;

  assign lanes   = req_data;
  assign operand = lanes[gidx];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  // Accept only while idle; gated by rst_n so nothing is accepted during reset.
  assign req_ready = (state == ST_IDLE && rst_n) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      settle_cnt <= '0;
      sig_in     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (any) begin
          ptr     <= (gidx == LAST) ? '0 : gidx + IW'(1);
          resp_id <= gidx;
          case (mode)
            ACT_SIGMOID: begin
              sig_in     <= operand;
              settle_cnt <= CNT_INIT;
              state      <= ST_WAIT;
            end
            ACT_RELU: begin
              resp_data  <= operand[31] ? FP_ZERO : operand;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end
            default: begin
              resp_data  <= operand;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end
          endcase
        end
        // sig_in is held for SETTLE_CYCLES cycles before sig_out is sampled.
        ST_WAIT: begin
          if (settle_cnt == '0) begin
            resp_data  <= sig_out;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ACT_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        op_count <= '0;
    else if (resp_valid && resp_ready) op_count <= op_count + 32'd1;
  end
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_activation_scheduler.sv
module tb_activation_scheduler;
  localparam int N  = 4;
  localparam int SC = 3;
  localparam int P  = 10;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [N-1:0]      req_valid = '0;
  logic [N*32-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [31:0]       sig_in;
  logic [31:0]       sig_out = 32'h3F00_0000;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic [IW-1:0]     resp_id;
  logic              resp_ready = 1'b0;
  logic [31:0]       op_count;
  logic [31:0]       lane_data [N];

  int checks = 0, errors = 0, rr = 0, ops_done = 0;

  always #(P/2) clk = ~clk;

  activation_scheduler #(.NUM_REQ(N), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .sig_in(sig_in), .sig_out(sig_out), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_id(resp_id), .resp_ready(resp_ready), .op_count(op_count)
  );

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*32 +: 32] = lane_data[i];
  end

  // External sigmoid datapath stand-in: 0 -> 0.5, otherwise an arbitrary fixed map.
  function automatic logic [31:0] sig_f(input logic [31:0] x);
    if (x == 32'h0) return 32'h3F00_0000;
    return {1'b0, x[30:0]} ^ 32'h0F0F_0F0F;
  endfunction

  // Output is garbage until the input has been stable for just under SC cycles,
  // so sampling one cycle early is visible.
  always begin
    @(sig_in);
    sig_out = 32'hDEAD_BEEF;
    #(SC*P - 2);
    sig_out = sig_f(sig_in);
  end

  function automatic int pick(input logic [N-1:0] mask, input int p);
    for (int k = 0; k < N; k++)
      if (mask[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] exp_res(input logic [1:0] md, input logic [31:0] d);
    if (md == 2'd2) return sig_f(d);
    if (md == 2'd1) return d[31] ? 32'h0 : d;
    return d;
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef ACT_SCHED_STATS_EN
    return 32'(ops_done);
`else
    return 32'h0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation: present mask/mode at a negedge, expect the model's lane,
  // optionally stall the response, then complete the handshake.
  task automatic run_op(input logic [N-1:0] mask, input logic [1:0] md,
                        input int stall, input bit drop);
    int g, lat, w;
    logic [31:0] ed, hold_sig;
    g  = pick(mask, rr);
    ed = exp_res(md, lane_data[g]);
    req_valid = mask; mode = md; resp_ready = 1'b0;
    #1;
    w = 0;
    while (req_ready == '0 && w < 20) begin @(negedge clk); #1; w++; end
    if (req_ready == '0) begin
      checks++; errors++;
      $error("FAIL grant_timeout: observed no req_ready expected lane %0d", g);
      return;
    end
    chk("req_ready", 32'(req_ready), 32'(1 << g));
    rr = (g + 1) % N;
    @(posedge clk); #1;
    mode = 2'($urandom_range(0, 3));   // must not affect the in-flight op
    if (drop) req_valid[g] = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), (md == 2'd2) ? 32'(SC + 1) : 32'd1);
    chk("resp_data", resp_data, ed);
    chk("resp_id", 32'(resp_id), 32'(g));
    hold_sig = sig_in;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_data", resp_data, ed);
      chk("stall_id", 32'(resp_id), 32'(g));
      chk("stall_no_ready", 32'(req_ready), 32'd0);
      chk("stall_sig_in", sig_in, hold_sig);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    ops_done++;
    @(negedge clk);
    chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    chk("op_count", op_count, exp_cnt());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_sig_in"}, sig_in, 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    chk({tag, "_op_count"}, op_count, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) lane_data[i] = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: all lanes held valid, PASS, one long backpressure stall.
    lane_data[0] = 32'h11; lane_data[1] = 32'h22;
    lane_data[2] = 32'h33; lane_data[3] = 32'h44;
    run_op(4'b1111, 2'd0, 0, 1'b0);
    run_op(4'b1111, 2'd0, 5, 1'b0);
    run_op(4'b1111, 2'd0, 0, 1'b0);
    run_op(4'b1111, 2'd0, 0, 1'b0);
    run_op(4'b1111, 2'd0, 0, 1'b1);
    req_valid = '0;

    // Single SIGMOID on lane 0, operand 0.0 -> 0.5.
    lane_data[0] = 32'h0;
    run_op(4'b0001, 2'd2, 0, 1'b1);

    // RELU on lane 2: -1.0 clamps to 0, 2.0 passes.
    lane_data[2] = 32'hBF80_0000;
    run_op(4'b0100, 2'd1, 0, 1'b1);
    lane_data[2] = 32'h4000_0000;
    run_op(4'b0100, 2'd1, 1, 1'b1);

    // Randomized mix of masks, modes (incl. reserved 3), data and stalls.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++)
        lane_data[i] = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      run_op(N'($urandom_range(1, 15)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 3), 1'b1);
    end
    req_valid = '0;

    // Reset while a SIGMOID op is in WAIT.
    lane_data[1] = 32'h4040_0000;
    req_valid = 4'b0010; mode = 2'd2;
    #1;
    chk("mid_grant", 32'(req_ready), 32'(1 << pick(4'b0010, rr)));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("mid_wait_no_valid", 32'(resp_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    rr = 0; ops_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) lane_data[i] = 32'hA0 + 32'(i);
    run_op(4'b1111, 2'd0, 0, 1'b1);

    req_valid = '0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(P * 20000);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
